argmax_reader: RTL



---
 rtl/mlp_pkg.sv | 18 +
 rtl/fp32_gt.sv | 24 ++
 rtl/argmax_reader.sv | 113 +++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared FP32 types and helpers for the MLP pipeline blocks.
package mlp_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP32_QNAN    = 32'h7FC00000;
  localparam fp32_t FP32_NEG_INF = 32'hFF800000;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } argmax_state_t;

  function automatic logic fp32_is_nan(input fp32_t v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational FP32 a > b for NaN-free operands; +0 and -0 compare equal.
module fp32_gt
  import mlp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  always_comb begin
    gt = 1'b0;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
      gt = 1'b0;
    end else if (a[31] != b[31]) begin
      gt = ~a[31];
    end else if (!a[31]) begin
      gt = (a[30:0] > b[30:0]);
    end else begin
      // both negative: smaller magnitude is the larger value
      gt = (a[30:0] < b[30:0]);
    end
  end

endmodule

// File: rtl/argmax_reader.sv
// Sequential argmax over a serial stream of N_CLASSES FP32 activations.
// Optional ARGMAX_NAN_FLAG_EN adds res_nan, set when the frame held any NaN beat.
//
// state | meaning
// SCAN  | accepting activations, tracking running best
// HOLD  | result presented, waiting for res_ready
module argmax_reader
  import mlp_pkg::*;
#(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_index,
  output logic [31:0]      res_value
`ifdef ARGMAX_NAN_FLAG_EN
  ,
  output logic             res_nan
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  argmax_state_t    state;
  logic [IDX_W-1:0] cnt;
  logic             have_best;
  logic [IDX_W-1:0] best_idx;
  fp32_t            best_val;
`ifdef ARGMAX_NAN_FLAG_EN
  logic             nan_seen;
`endif

  logic accept;
  logic in_nan;
  logic in_gt;
  logic upd;
  logic last;

  assign in_ready  = (state == SCAN);
  assign res_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign in_nan    = fp32_is_nan(in_data);
  // best_val is a NaN while !have_best; in_gt is then masked by !have_best
  assign upd       = accept && !in_nan && (!have_best || in_gt);
  assign last      = accept && (cnt == LAST_IDX);

  fp32_gt u_gt (
    .a  (in_data),
    .b  (best_val),
    .gt (in_gt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= SCAN;
      cnt       <= '0;
      have_best <= 1'b0;
      best_idx  <= '0;
      best_val  <= FP32_QNAN;
      res_index <= '0;
      res_value <= FP32_QNAN;
`ifdef ARGMAX_NAN_FLAG_EN
      nan_seen  <= 1'b0;
      res_nan   <= 1'b0;
`endif
    end else begin
      case (state)
        SCAN: begin
          if (accept) begin
            if (upd) begin
              best_val  <= in_data;
              best_idx  <= cnt;
              have_best <= 1'b1;
            end
`ifdef ARGMAX_NAN_FLAG_EN
            nan_seen <= nan_seen | in_nan;
`endif
            if (last) begin
              cnt       <= '0;
              state     <= HOLD;
              res_index <= upd ? cnt : best_idx;
              res_value <= upd ? in_data : best_val;
`ifdef ARGMAX_NAN_FLAG_EN
              res_nan   <= nan_seen | in_nan;
`endif
            end else begin
              cnt <= cnt + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state     <= SCAN;
            have_best <= 1'b0;
            best_idx  <= '0;
            best_val  <= FP32_QNAN;
`ifdef ARGMAX_NAN_FLAG_EN
            nan_seen  <= 1'b0;
`endif
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
